mod_counter: RTL
================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, 4, counter width in bits; legal range 2..16.
REQ-002 Parameter MODULUS, 16, count modulus; legal range 2..2^WIDTH; default gives a full-range 4-bit count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; one step per clk rising edge while high.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 q  output  WIDTH  registered count value.
REQ-010 tc  output  1  terminal count, combinational from registered state and inputs.
REQ-011 ovf_clr  input  1  sticky-overflow clear; present only when MOD_COUNTER_OVF_STICKY_EN is defined.
REQ-012 ovf  output  1  sticky overflow flag; present only when MOD_COUNTER_OVF_STICKY_EN is defined.

Function
REQ-013 Fully synchronous counter: all flops clocked by clk alone; no flop output is used as a clock (no ripple).
REQ-014 Per-edge priority: load > en > hold.
REQ-015 load=1: q <= d when d < MODULUS, otherwise q <= MODULUS-1; en and up ignored that cycle.
REQ-016 load=0, en=1, up=1: q <= q+1, except q = MODULUS-1 gives q <= 0.
REQ-017 load=0, en=1, up=0: q <= q-1, except q = 0 gives q <= MODULUS-1.
REQ-018 load=0, en=0: q holds.
REQ-019 tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)); tc is high exactly in the cycle whose edge wraps q.
REQ-020 Latency: q reflects load/count one clk edge after the qualifying inputs are sampled; tc has zero latency.
REQ-021 Direction change takes effect on the very next counting edge; no dead cycle.
REQ-022 Arithmetic is modulo MODULUS; q never exceeds MODULUS-1 after reset, including when MODULUS < 2^WIDTH.
REQ-023 en held high for MODULUS consecutive edges with constant up returns q to its starting value.

Reset
REQ-024 clr low forces q = 0 (and ovf = 0 when compiled in) immediately, independent of clk.
REQ-025 While clr is low, load, en and ovf_clr are ignored; the first counting edge after clr rises acts on q = 0.
REQ-026 Reset asserted mid-count or mid-load aborts the operation; no partial update survives.
REQ-027 Outputs remain free of X after reset, with inputs at any legal value.

Configuration
REQ-028 Macro MOD_COUNTER_OVF_STICKY_EN selects the sticky overflow feature.
REQ-029 Defined: ovf sets on any edge where tc=1; it holds until ovf_clr=1 at an edge or clr is low.
REQ-030 Defined: when ovf_clr=1 and tc=1 on the same edge, set wins and ovf stays 1.
REQ-031 Not defined: the ovf and ovf_clr ports and their flop do not exist; all other behaviour is identical.

Verification
REQ-032 WIDTH=4, MODULUS=10, up=1, en=1 for 12 edges from reset -> q runs 1..9, 0, 1, 2; tc high only while q=9.
REQ-033 WIDTH=4, MODULUS=10, up=0, en=1 from reset -> first edge q=9, tc high at q=0; then q=8, 7, ...
REQ-034 load=1, d=12 with MODULUS=10 -> q=9; load=1 with en=1, d=3 -> q=3 (load wins over count).
REQ-035 clr pulled low between edges at q=6 -> q=0 immediately without a clk edge; count resumes at 1 after release.
REQ-036 OVF_STICKY_EN defined, MODULUS=10, count through a wrap -> ovf=1 and held.
REQ-037 OVF_STICKY_EN defined: ovf_clr=1 with tc=0 -> ovf=0; ovf_clr=1 with tc=1 -> ovf stays 1.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: synchronous up/down modulo counter with load; MOD_COUNTER_OVF_STICKY_EN adds sticky overflow
module mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
`ifdef MOD_COUNTER_OVF_STICKY_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf
`endif
);
    // one extra bit so MODULUS == 2^WIDTH is representable for the load clamp
    localparam logic [WIDTH:0]   modv = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] top  = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] q_nxt;
    always_comb begin
        tc    = en & ~load & (up ? (q == top) : (q == '0));
        q_nxt = load ? (({1'b0, d} < modv) ? d : top) :
                en   ? (up ? ((q == top) ? '0 : q + 1'b1) : ((q == '0) ? top : q - 1'b1)) :
                q;
    end
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= '0;
        else      q <= q_nxt;
`ifdef MOD_COUNTER_OVF_STICKY_EN
    always_ff @(posedge clk or negedge clr)
        if (!clr)        ovf <= 1'b0;
        else if (tc)     ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
`endif
endmodule
